// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Frame layout: start, 8 data bits LSB-first, odd parity, stop.
package kbd_pkg;
  localparam int FRAME_BITS    = 11;
  localparam int PARITY_IDX    = 9;
  localparam int STOP_IDX      = 10;

  localparam int DOUT_NONEMPTY = 8;
  localparam int DOUT_OVF      = 9;
  localparam int DOUT_FERR     = 10;

  typedef enum logic {IDLE, RECV} rx_state_e;

  // v = {parity, data}; odd parity means an odd number of ones overall.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a pop in the same cycle as a push frees the slot
// first, so a push into a full FIFO succeeds when paired with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       clrn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames,
// queues good scancodes and exposes head/status/sticky errors in one read word.
module ps2_kbd_rx
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        en,
  output logic [31:0] dout,
  output logic        irq
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   ps2_clk_s, ps2_data_s, ps2_clk_s_q;
  logic                   fall;

  rx_state_e   state;
  logic [3:0]  bitcnt;
  logic [8:0]  shreg;
  logic [TW-1:0] tcnt;

  logic        en_q, rise;
  logic        ovf, ferr;
  logic        frame_end, frame_ok, timeout;
  logic        push, ovf_set, ferr_set;

  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
  assign ps2_data_s = dat_sync[SYNC_STAGES-1];
  assign fall       = ps2_clk_s_q & ~ps2_clk_s;
  assign rise       = en & ~en_q;

  // Synchronisers reset to 1 so an idle bus never looks like a falling edge.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      clk_sync    <= '1;
      dat_sync    <= '1;
      ps2_clk_s_q <= 1'b1;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync    <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      ps2_clk_s_q <= ps2_clk_s;
    end
  end

  // shreg holds {parity, data[7:0]} once the stop bit arrives.
  always_comb begin
    frame_end = (state == RECV) && fall && (bitcnt == 4'(STOP_IDX));
    frame_ok  = odd_parity_ok(shreg) && ps2_data_s;
    timeout   = (state == RECV) && !fall && (tcnt == T_LAST);
    push      = frame_end & frame_ok;
    ovf_set   = push & fifo_full & ~rise;
    ferr_set  = (frame_end & ~frame_ok) | timeout;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      tcnt   <= '0;
    end else begin
      if (fall || state != RECV || timeout) tcnt <= '0;
      else                                   tcnt <= tcnt + T_ONE;

      case (state)
        IDLE: if (fall && !ps2_data_s) begin
          state  <= RECV;
          bitcnt <= 4'd1;
          shreg  <= '0;
        end
        RECV: begin
          if (fall) begin
            if (bitcnt == 4'(STOP_IDX)) begin
              state  <= IDLE;
              bitcnt <= '0;
            end else begin
              shreg  <= {ps2_data_s, shreg[8:1]};
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (timeout) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as the clearing read wins.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      en_q <= 1'b0;
      ovf  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      en_q <= en;
      ovf  <= ovf_set  | (ovf  & ~rise);
      ferr <= ferr_set | (ferr & ~rise);
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .clrn  (clrn),
    .push  (push),
    .din   (shreg[7:0]),
    .pop   (rise & ~fifo_empty),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    dout                = '0;
    dout[7:0]           = fifo_head;
    dout[DOUT_NONEMPTY] = (fifo_count != '0);
    dout[DOUT_OVF]      = ovf;
    dout[DOUT_FERR]     = ferr;
    irq                 = (fifo_count != '0);
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-level model.
module tb_ps2_kbd_rx;
  localparam int D  = 8;
  localparam int T  = 64;
  localparam int S  = 2;
  localparam int HP = 5;

  logic clock = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, en = 0;
  logic [31:0] dout;
  logic irq;

  int checks = 0, failures = 0;
  int cyc = 0;

  ps2_kbd_rx #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .clock(clock), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .en(en), .dout(dout), .irq(irq)
  );

  always #5 clock = ~clock;

  // Model: circular store with head index, sticky flags, and frame outcomes
  // scheduled for the cycle on which the receiver acts on the pin edge.
  typedef struct { int at; int kind; logic [7:0] data; } ev_t;
  ev_t evq[$];
  logic [7:0] m_mem [D];
  int m_rd, m_wr, m_cnt;
  bit m_ovf, m_ferr, m_en_prev;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
    m_rd = 0; m_wr = 0; m_cnt = 0;
    m_ovf = 0; m_ferr = 0; m_en_prev = 0;
    evq.delete();
  endfunction

  function automatic logic [31:0] model_dout();
    return {21'b0, m_ferr, m_ovf, (m_cnt != 0), m_mem[m_rd]};
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (!clrn) model_reset();
    else begin
      if (en && !m_en_prev) begin
        if (m_cnt > 0) begin m_rd = (m_rd + 1) % D; m_cnt--; end
        m_ovf = 0; m_ferr = 0;
      end
      m_en_prev = en;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].at == cyc) begin
          if (evq[i].kind == 0) begin
            if (m_cnt < D) begin
              m_mem[m_wr] = evq[i].data; m_wr = (m_wr + 1) % D; m_cnt++;
            end else m_ovf = 1;
          end else m_ferr = 1;
          evq.delete(i);
        end
      end
    end
  end

  always @(posedge clock) begin
    logic [31:0] exp;
    #2;
    exp = model_dout();
    checks++;
    if (dout !== exp || irq !== exp[8]) begin
      failures++;
      $display("FAIL cycle_cmp @%0d: dout=%h irq=%b required dout=%h irq=%b",
               cyc, dout, irq, exp, exp[8]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // nbits < 11 sends a truncated frame; align_pop raises en so its rising
  // edge is seen on the same cycle the stop bit is acted on.
  task automatic send_frame(input logic [7:0] d, input bit bad_par = 0,
                            input bit bad_stop = 0, input int nbits = 11,
                            input bit align_pop = 0);
    logic [10:0] b;
    bit ok;
    b[0] = 1'b0;
    b[8:1] = d;
    b[9] = ($countones(d) % 2 == 0) ^ bad_par;
    b[10] = ~bad_stop;
    ok = ($countones(b[9:1]) % 2 == 1) && b[10];
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock) ps2_data = b[i];
      repeat (HP - 1) @(negedge clock);
      ps2_clk = 0;
      if (i == 10) evq.push_back('{cyc + S + 1, ok ? 0 : 1, d});
      else if (i == nbits - 1) evq.push_back('{cyc + S + 1 + T, 2, 8'h00});
      if (align_pop && i == 10) begin
        repeat (S) @(negedge clock);
        en = 1;
        repeat (HP - S) @(negedge clock);
      end else repeat (HP) @(negedge clock);
      ps2_clk = 1;
    end
    if (align_pop) en = 0;
    ps2_data = 1;
    repeat (HP) @(negedge clock);
  endtask

  task automatic read_pulse(input int len = 1);
    @(negedge clock) en = 1;
    repeat (len) @(negedge clock);
    en = 0;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock) clrn = 0; en = 0; ps2_clk = 1; ps2_data = 1;
    model_reset();
    repeat (n) @(negedge clock);
    clrn = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a_done;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_dout", dout, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    clrn = 1;
    repeat (3) @(negedge clock);

    send_frame(8'h1C);
    chk("frame_1c", dout, 32'h0000011C);
    chk("irq_1c", {31'b0, irq}, 32'h1);
    read_pulse(5);
    chk("pop_once", dout, 32'h0);

    send_frame(8'hF0, 1);
    chk("bad_parity", dout, 32'h00000400);
    read_pulse();
    chk("ferr_clear", dout, 32'h0);

    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    chk("overflow", dout, 32'h00000301);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("pop_head_%0d", i), {24'b0, dout[7:0]}, 32'(i));
      read_pulse();
    end
    chk("drained_nonempty", {31'b0, dout[8]}, 32'h0);

    send_frame(8'hA5, 0, 0, 5);
    repeat (T + 10) @(negedge clock);
    chk("timeout_ferr", {31'b0, dout[10]}, 32'h1);
    send_frame(8'h2A);
    chk("after_timeout", dout, 32'h0000052A);
    read_pulse();

    for (int i = 0; i < 8; i++) send_frame(8'(8'h60 + i));
    send_frame(8'h55, 0, 0, 11, 1);
    chk("full_pushpop_ovf", {30'b0, dout[9:8]}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("full_head_%0d", i), {24'b0, dout[7:0]}, 32'(8'h60 + i));
      read_pulse();
    end
    chk("last_is_55", dout, 32'h00000155);
    read_pulse();
    chk("full_drained", {31'b0, dout[8]}, 32'h0);

    send_frame(8'hC3, 0, 0, 5);
    do_reset(3);
    send_frame(8'h33);
    chk("reset_midframe", dout, 32'h00000133);

    // lone falling edge with data high must be ignored
    @(negedge clock) ps2_data = 1;
    repeat (HP) @(negedge clock) ps2_clk = 0;
    repeat (HP) @(negedge clock) ps2_clk = 1;
    repeat (HP) @(negedge clock);
    chk("glitch_ignored", dout, 32'h00000133);
    send_frame(8'h00, 0, 1);
    chk("bad_stop", dout, 32'h00000533);
    read_pulse();

    a_done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int r = $urandom_range(0, 99);
          if (r < 10) begin
            send_frame(8'($urandom), 0, 0, $urandom_range(1, 10));
            repeat (T + 5) @(negedge clock);
          end else send_frame(8'($urandom), r < 25, (r >= 25 && r < 33));
        end
        a_done = 1;
      end
      begin
        while (!a_done) begin
          repeat ($urandom_range(0, 60)) @(negedge clock);
          if (!a_done) read_pulse($urandom_range(1, 4));
        end
      end
    join

    repeat (20) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
